// File: rtl/fetch_queue.sv
// Fetch-stage queue: advances the PC, issues imem reads and buffers {pc, instr} for decode.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [XLEN-1:0]          pc,
  output logic                     pc_en,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  input  logic                     flush,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [XLEN-1:0]          dec_instr,
  output logic [XLEN-1:0]          dec_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic [XLEN-1:0] mem_pc_q    [DEPTH];
  logic [XLEN-1:0] mem_instr_q [DEPTH];

  logic            fifo_valid;
  logic            byp;
  logic            pop_fifo;
  logic            pop_byp;
  logic            wr;
  logic            issue;
  logic [CW:0]     credit;

  always_comb begin
    fifo_valid = (count_q != '0);
`ifdef FETCH_BYPASS_EN
    byp        = (count_q == '0) & inflight_q & ~flush;
`else
    byp        = 1'b0;
`endif
    pop_fifo   = fifo_valid & dec_ready & ~flush;
    pop_byp    = byp & dec_ready;
    // A response consumed through the bypass never occupies a FIFO slot.
    wr         = inflight_q & ~flush & ~pop_byp;
    // Slots promised = held entries + the response still on its way, less this cycle's pop.
    credit     = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop_fifo | pop_byp);
    issue      = ~rst & ~flush & (credit < (CW+1)'(DEPTH));

    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = issue;
    pc_d       = pc_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_q + CW'(wr) - CW'(pop_fifo);
      rd_ptr_d = rd_ptr_q + AW'(pop_fifo);
      wr_ptr_d = wr_ptr_q + AW'(wr);
      if (issue) pc_d = pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inflight_q <= 1'b0;
      pc_q       <= '0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
      pc_q       <= pc_d;
    end
  end

  // Storage carries data only; validity is tracked entirely by count/pointers.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_pc_q[wr_ptr_q]    <= pc_q;
      mem_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_req  = issue;
  assign imem_addr = pc;
  assign pc_en     = ~rst & (issue | flush);
  assign occupancy = count_q;

`ifdef FETCH_BYPASS_EN
  assign dec_valid = fifo_valid | byp;
  assign dec_pc    = byp ? pc_q       : mem_pc_q[rd_ptr_q];
  assign dec_instr = byp ? imem_rdata : mem_instr_q[rd_ptr_q];
`else
  assign dec_valid = fifo_valid;
  assign dec_pc    = mem_pc_q[rd_ptr_q];
  assign dec_instr = mem_instr_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a PC register and imem model drive the DUT; an
// in-order list of issued {pc, instr} pairs is the expected decode stream.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        dec_ready = 1'b0;
  logic [31:0] flush_tgt = 32'h0;
  logic [31:0] pc = 32'h0;
  logic [31:0] imem_rdata = 32'h0;

  logic        pc_en, imem_req, dec_valid;
  logic [31:0] imem_addr, dec_instr, dec_pc;
  logic [2:0]  occupancy;

  int vectors = 0;
  int miscompares = 0;

  ent_t        q[$];
  logic        infl_m = 1'b0;
  logic        iss_m = 1'b0;
  logic        fl_m = 1'b0;
  logic [31:0] tgt_m = 32'h0;
  logic        pen_l = 1'b0;
  logic        req_l = 1'b0;
  logic [31:0] addr_l = 32'h0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fn(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare every cycle against the list of outstanding fetches.
  always @(negedge clk) begin
    int   exp_occ;
    logic exp_valid, exp_pop, exp_issue;
    if (rst) begin
      chk("rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_pc_en", 32'(pc_en), 32'd0);
      q.delete();
      iss_m = 1'b0;
      fl_m  = 1'b0;
      pen_l = 1'b0;
      req_l = 1'b0;
    end else begin
      exp_occ   = q.size() - int'(infl_m);
      exp_valid = (exp_occ != 0);
`ifdef FETCH_BYPASS_EN
      if (infl_m && !flush) exp_valid = 1'b1;
`endif
      chk("occupancy", 32'(occupancy), 32'(exp_occ));
      chk("dec_valid", 32'(dec_valid), 32'(exp_valid));
      if (exp_valid && dec_valid && q.size() > 0) begin
        chk("dec_pc", dec_pc, q[0].pc);
        chk("dec_instr", dec_instr, q[0].instr);
      end
      exp_pop   = exp_valid & dec_ready & !flush;
      exp_issue = !flush && ((q.size() - int'(exp_pop)) < DEPTH);
      chk("imem_req", 32'(imem_req), 32'(exp_issue));
      chk("pc_en", 32'(pc_en), 32'(exp_issue | flush));
      chk("imem_addr", imem_addr, pc);
      if (exp_pop) void'(q.pop_front());
      iss_m  = exp_issue;
      fl_m   = flush;
      tgt_m  = flush_tgt;
      pen_l  = pc_en;
      req_l  = imem_req;
      addr_l = imem_addr;
    end
  end

  // Environment: PC register, 1-cycle imem, and the scoreboard push on each issue.
  always @(posedge clk) begin
    if (rst) begin
      pc <= 32'h0;
      infl_m = 1'b0;
      q.delete();
    end else if (fl_m) begin
      pc <= tgt_m;
      infl_m = 1'b0;
      q.delete();
    end else begin
      if (iss_m) q.push_back(ent_t'({pc, fn(pc)}));
      infl_m = iss_m;
      if (pen_l) pc <= pc + 32'd4;
    end
    imem_rdata <= req_l ? fn(addr_l) : $urandom;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; dec_ready = 1'b0;
    repeat (2) cyc();
  endtask

  initial begin
    int occ_a;

    // Reset and first fetch
    do_reset();
    dec_ready = 1'b1;
    rst = 1'b0;
    #1;
    chk("first_pc_en", 32'(pc_en), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    cyc(); #1;
`ifdef FETCH_BYPASS_EN
    chk("byp_valid_c1", 32'(dec_valid), 32'd1);
    chk("byp_pc_c1", dec_pc, 32'h0);
    chk("byp_instr_c1", dec_instr, 32'h00000013);
`else
    chk("valid_c1", 32'(dec_valid), 32'd0);
    cyc(); #1;
    chk("valid_c2", 32'(dec_valid), 32'd1);
    chk("pc_c2", dec_pc, 32'h0);
    chk("instr_c2", dec_instr, 32'h00000013);
`endif

    // Fill to full, then stream with simultaneous push/pop
    do_reset();
    rst = 1'b0;
    repeat (8) cyc();
    #1;
    chk("full_occ", 32'(occupancy), 32'd4);
    chk("full_pc_en", 32'(pc_en), 32'd0);
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_pc_hold", pc, 32'h10);
    dec_ready = 1'b1;
    repeat (4) cyc();
    #1;
    occ_a = int'(occupancy);
    cyc(); #1;
    chk("stream_occ_steady", 32'(occupancy), 32'(occ_a));
    chk("stream_issue", 32'(imem_req), 32'd1);
    repeat (6) cyc();

    // Flush with 3 queued and 0x20 in flight
    do_reset();
    rst = 1'b0; flush = 1'b1; flush_tgt = 32'h14;
    cyc(); flush = 1'b0;
    repeat (4) cyc();
    #1;
    chk("preflush_occ", 32'(occupancy), 32'd3);
    chk("preflush_pc", pc, 32'h24);
    flush = 1'b1; flush_tgt = 32'h100;
    cyc(); flush = 1'b0; dec_ready = 1'b1;
    #1;
    chk("flush_occ", 32'(occupancy), 32'd0);
    for (int i = 0; i < 6 && !dec_valid; i++) begin cyc(); #1; end
    chk("flush_wait_valid", 32'(dec_valid), 32'd1);
    chk("flush_first_pc", dec_pc, 32'h100);
    repeat (4) cyc();

    // Reset mid-operation: 2 queued, 1 in flight
    do_reset();
    rst = 1'b0;
    repeat (3) cyc();
    chk("premid_occ", 32'(occupancy), 32'd2);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(dec_valid), 32'd0);
    chk("midrst_occ", 32'(occupancy), 32'd0);
    cyc(); cyc();
    rst = 1'b0; dec_ready = 1'b1;
    for (int i = 0; i < 6 && !dec_valid; i++) begin cyc(); #1; end
    chk("midrst_wait_valid", 32'(dec_valid), 32'd1);
    chk("midrst_first_pc", dec_pc, 32'h0);

    // Random traffic: wrap, back-pressure, flushes and occasional reset
    for (int i = 0; i < 400; i++) begin
      cyc();
      rst       = ($urandom_range(0, 127) == 0);
      dec_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 31) == 0);
      flush_tgt = {16'h0, 14'($urandom), 2'b00};
    end
    cyc();
    rst = 1'b0; flush = 1'b0; dec_ready = 1'b1;
    repeat (10) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
